div_raw: RTL
============

Name: div_raw

Overview:
- Sequential unsigned restoring divider. It is the inverse-operation companion to the shift-add multiplier in the DSP arithmetic library.
- It accepts a dividend/divisor pair on a single-cycle vld strobe and iterates one quotient bit per clock, MSB first.
- It presents quotient and remainder for exactly one cycle with res_vld.
- It sits beside the multiplier in low-area datapaths where a combinational divider is too large.

Parameters:
- N, 8, dividend and quotient width (N >= 2)
- M, 4, divisor and remainder width (M >= 2, M <= N)

Ports:
- clk  input  1  clock, rising-edge
- rstn  input  1  reset, asynchronous, active-low
- vld  input  1  operand strobe; sampled only when busy=0
- dividend  input  N  unsigned dividend
- divisor  input  M  unsigned divisor
- busy  output  1  high whenever state != IDLE
- quot  output  N  quotient; zero when res_vld=0
- rem  output  M  remainder; zero when res_vld=0
- div_zero  output  1  divide-by-zero flag; valid only with res_vld, otherwise 0
- res_vld  output  1  one-cycle result strobe

Behaviour:
- Reset: rstn is asynchronous, active-low; clk is the clock. While rstn=0: state=IDLE, all internal registers 0, busy=0, quot=0, rem=0, div_zero=0, res_vld=0.
- FSM states: IDLE, CALC, DONE.
- IDLE & vld & divisor!=0 at edge k:
  - capture dividend into shift register q_sh[N-1:0] and divisor into d_reg[M-1:0]
  - clear partial remainder pr[M:0] (M+1 bits)
  - set cnt=N-1; go to CALC.
- IDLE & vld & divisor==0 at edge k: set zero flag; go directly to DONE; no iteration.
- IDLE & !vld: stay in IDLE.
- CALC, one iteration per edge:
  - t = {pr[M-1:0], q_sh[N-1]} (M+1 bits)
  - if t >= {1'b0,d_reg}: pr <= t - d_reg and q_sh <= {q_sh[N-2:0],1}
  - else: pr <= t and q_sh <= {q_sh[N-2:0],0}
  - if cnt==0 go to DONE, else cnt <= cnt-1.
- Latency, normal case: CALC occupies exactly N cycles; state=DONE after edge k+N; res_vld high during the cycle following edge k+N, so it is sampled high at edge k+N+1.
- Latency, divide-by-zero: res_vld is high during the cycle following edge k.
- DONE: res_vld=1, busy=1 for exactly one cycle, then IDLE unconditionally.
  - Normal case: quot=q_sh, rem=pr[M-1:0], div_zero=0.
  - Divide-by-zero: quot={N{1'b1}}, rem=0, div_zero=1.
- Output gating: outputs are gated by state==DONE and are zero in all other states.
- Width rule: pr never exceeds 2*d_reg-1, so M+1 bits suffice and the subtraction never underflows. The final pr[M] is always 0.
- vld while busy=1 (CALC or DONE): ignored; operands are not recaptured and the in-flight result is unaffected.
- Back-to-back: the earliest next acceptance is the IDLE cycle after DONE, so throughput is one result per N+2 cycles.
- Operands may change freely after the accepting edge; only captured values are used.
- Reset mid-operation (CALC or DONE): immediate abort to IDLE; no res_vld is produced for the aborted operation.
- cnt width: $clog2(N).

Decomposition:
- Shared package dsp_arith_pkg:
  - state localparams IDLE=2'b00, CALC=2'b01, DONE=2'b10
  - the state type width, shared with the multiplier FSM encoding.
- One natural combinational sub-module, div_raw_step (parameter M):
  - inputs pr[M-1:0], next dividend bit, d_reg
  - outputs new pr[M:0] and the quotient bit
- The FSM, counter, and output gating stay in div_raw.

Test Plan:
- N=8,M=4: vld with dividend=200, divisor=7 at edge k -> res_vld=1 sampled at edge k+9 only, quot=28, rem=4, div_zero=0; busy high edges k+1..k+9.
- dividend=255, divisor=1 -> quot=255, rem=0. Then dividend=5, divisor=9 -> quot=0, rem=5. Two jobs back-to-back, second vld held high continuously: accepted only on the IDLE cycle after the first DONE.
- dividend=255, divisor=15 -> quot=17, rem=0. dividend=0, divisor=3 -> quot=0, rem=0.
- divisor=0, dividend=77 at edge k -> res_vld at edge k+1 only (one cycle), quot=0xFF, rem=0, div_zero=1; busy=1 in that cycle.
- Start 200/7, then pulse vld with 9/3 at cycles k+3 and k+9 (busy) -> single result quot=28, rem=4; no second res_vld.
- Start 200/7, assert rstn=0 asynchronously mid-CALC (between edges) -> busy, res_vld, quot, rem drop to 0 immediately. After release, a new 100/10 gives quot=10, rem=0 with normal latency.

Source files
------------

// File: rtl/dsp_arith_pkg.sv
// State encoding shared by the sequential arithmetic blocks (shift-add multiplier, restoring divider).
// Both FSMs use the same width and values so their control logic reads alike.
package dsp_arith_pkg;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_e;
endpackage

// File: rtl/div_raw_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial remainder,
// then subtract the divisor if it fits. The result never exceeds 2*d_reg-1, so M+1 bits are enough.
module div_raw_step #(
    parameter int M = 4
) (
    input  logic [M-1:0] pr,
    input  logic         dvd_bit,
    input  logic [M-1:0] d_reg,
    output logic [M:0]   pr_next,
    output logic         q_bit
);
    logic [M:0] t;
    logic [M:0] d_ext;

    always_comb begin
        t       = {pr, dvd_bit};
        d_ext   = {1'b0, d_reg};
        pr_next = t;
        q_bit   = 1'b0;
        if (t >= d_ext) begin
            pr_next = t - d_ext;
            q_bit   = 1'b1;
        end
    end
endmodule

// File: rtl/div_raw.sv
// Sequential unsigned restoring divider: one quotient bit per clock, MSB first.
// Quotient/remainder are presented for a single cycle with res_vld; a zero divisor skips iteration.
module div_raw
    import dsp_arith_pkg::*;
#(
    parameter int N = 8,
    parameter int M = 4
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         vld,
    input  logic [N-1:0] dividend,
    input  logic [M-1:0] divisor,
    output logic         busy,
    output logic [N-1:0] quot,
    output logic [M-1:0] rem,
    output logic         div_zero,
    output logic         res_vld
);
    localparam int            CW       = $clog2(N);
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    state_e        state_q, state_d;
    logic [N-1:0]  q_sh_q, q_sh_d;
    logic [M-1:0]  d_q, d_d;
    logic [M:0]    pr_q, pr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          zero_q, zero_d;

    logic [M:0]    pr_next;
    logic          q_bit;
    logic          unused_pr_msb;

    // The partial remainder's top bit is always 0 between iterations; only the low M bits feed back.
    assign unused_pr_msb = pr_q[M];

    div_raw_step #(.M(M)) u_step (
        .pr      (pr_q[M-1:0]),
        .dvd_bit (q_sh_q[N-1]),
        .d_reg   (d_q),
        .pr_next (pr_next),
        .q_bit   (q_bit)
    );

    always_comb begin
        state_d = state_q;
        q_sh_d  = q_sh_q;
        d_d     = d_q;
        pr_d    = pr_q;
        cnt_d   = cnt_q;
        zero_d  = zero_q;
        unique case (state_q)
            IDLE: begin
                if (vld) begin
                    if (divisor == '0) begin
                        zero_d  = 1'b1;
                        state_d = DONE;
                    end else begin
                        zero_d  = 1'b0;
                        q_sh_d  = dividend;
                        d_d     = divisor;
                        pr_d    = '0;
                        cnt_d   = CNT_INIT;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                pr_d   = pr_next;
                q_sh_d = {q_sh_q[N-2:0], q_bit};
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
            q_sh_q  <= '0;
            d_q     <= '0;
            pr_q    <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            q_sh_q  <= q_sh_d;
            d_q     <= d_d;
            pr_q    <= pr_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    // Results are visible only during DONE; every other state drives zeros.
    always_comb begin
        busy     = (state_q != IDLE);
        res_vld  = 1'b0;
        quot     = '0;
        rem      = '0;
        div_zero = 1'b0;
        if (state_q == DONE) begin
            res_vld  = 1'b1;
            div_zero = zero_q;
            quot     = zero_q ? '1 : q_sh_q;
            rem      = zero_q ? '0 : pr_q[M-1:0];
        end
    end
endmodule
